// File: rtl/ps2_mouse_receiver.sv
// ps2_mouse_receiver
// Receives 11-bit PS/2 device-to-host frames (start, 8 data LSB-first, odd
// parity, stop) in the CLK domain. Each completed frame produces a one-cycle
// BYTE_READY pulse. BYTE_READ and BYTE_ERROR_CODE update in that same cycle.
// Frames with errors still pulse. The master decides whether to discard them.
// Optional feature: define PS2_RX_TIMEOUT_EN to abandon a partial frame after
// TIMEOUT_CYCLES clocks without a PS/2 falling edge.
module ps2_mouse_receiver #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic       BYTE_READY,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE
);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    DATA   = 5'b00010,
    PARITY = 5'b00100,
    STOP   = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] clk_dly, data_dly;
  logic       clk_fall, data_bit;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       parity_err, stop_err;
  logic       shift_en, cnt_clr, cap_par, cap_stop, load_out;
  logic       wd_expired;

  // Three-flop synchronisers. They reset high because idle PS/2 lines are high.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_dly  <= 3'b111;
      data_dly <= 3'b111;
    end else begin
      clk_dly  <= {clk_dly[1:0], CLK_MOUSE_IN};
      data_dly <= {data_dly[1:0], DATA_MOUSE_IN};
    end
  end

  assign clk_fall = clk_dly[2] & ~clk_dly[1];
  // data_dly[1] has passed through the same number of flops as the edge detect.
  assign data_bit = data_dly[1];

`ifdef PS2_RX_TIMEOUT_EN
  localparam logic [16:0] WD_LIMIT = 17'(TIMEOUT_CYCLES - 1);
  logic [16:0] wd_cnt;

  // Watchdog restarts on every PS/2 edge and stays cleared while idle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                        wd_cnt <= '0;
    else if (clk_fall || state == IDLE) wd_cnt <= '0;
    else                               wd_cnt <= wd_cnt + 17'd1;
  end

  assign wd_expired = (wd_cnt == WD_LIMIT) && (state != IDLE);
`else
  assign wd_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath strobes. Abort and timeout override every state
  // except DONE, so a frame that has already completed always reports.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    cap_par   = 1'b0;
    cap_stop  = 1'b0;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        // A start bit must be 0. A 1 is treated as line noise and dropped.
        if (clk_fall && !data_bit) begin
          state_nxt = DATA;
          cnt_clr   = 1'b1;
        end
      end
      DATA: begin
        if (clk_fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (clk_fall) begin
          cap_par   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (clk_fall) begin
          cap_stop  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        load_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != DONE && (!READ_ENABLE || wd_expired)) begin
      state_nxt = IDLE;
      shift_en  = 1'b0;
      cap_par   = 1'b0;
      cap_stop  = 1'b0;
      cnt_clr   = 1'b1;
    end
  end

  // Frame datapath: shift register, bit counter, error flags.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_err <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      if (cnt_clr)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {data_bit, shreg[7:1]};
      // The eight data bits plus the parity bit must hold an odd number of ones.
      if (cap_par)  parity_err <= ~(^shreg ^ data_bit);
      if (cap_stop) stop_err   <= ~data_bit;
    end
  end

  // Output registers update only in the DONE cycle.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      BYTE_READY      <= 1'b0;
      BYTE_READ       <= 8'h00;
      BYTE_ERROR_CODE <= 2'b00;
    end else begin
      BYTE_READY <= load_out;
      if (load_out) begin
        BYTE_READ       <= shreg;
        BYTE_ERROR_CODE <= {stop_err, parity_err};
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// Directed testbench for ps2_mouse_receiver.
// The PS/2 bit period is shortened to 2*H system clocks to keep runs short.
module tb_ps2_mouse_receiver;

  localparam int H = 20;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CLK_MOUSE_IN = 1'b1;
  logic       DATA_MOUSE_IN = 1'b1;
  logic       READ_ENABLE = 1'b1;
  logic       BYTE_READY;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int wide_cnt = 0;
  int stop_fall_cyc = 0;
  logic       rdy_q = 1'b0;
  logic [7:0] cap_byte = 8'h00;
  logic [1:0] cap_code = 2'b00;

  ps2_mouse_receiver dut (
    .CLK(CLK), .RESET(RESET), .CLK_MOUSE_IN(CLK_MOUSE_IN),
    .DATA_MOUSE_IN(DATA_MOUSE_IN), .READ_ENABLE(READ_ENABLE),
    .BYTE_READY(BYTE_READY), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE)
  );

  always #10 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling system-clock edge.
  always @(negedge CLK) begin
    if (BYTE_READY) begin
      pulse_cnt = pulse_cnt + 1;
      pulse_cyc = cyc;
      cap_byte  = BYTE_READ;
      cap_code  = BYTE_ERROR_CODE;
      if (rdy_q) wide_cnt = wide_cnt + 1;
    end
    rdy_q = BYTE_READY;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge CLK);
    DATA_MOUSE_IN = b;
    idle(H);
    CLK_MOUSE_IN = 1'b0;
    idle(H);
    CLK_MOUSE_IN = 1'b1;
  endtask

  // Full frame. If drop is set, READ_ENABLE is pulsed low for the cycle the
  // receiver sits in DONE (three clocks after the stop edge is driven).
  task automatic send_frame(input logic [7:0] d, input logic par,
                            input logic stp, input bit drop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    @(negedge CLK);
    DATA_MOUSE_IN = stp;
    idle(H);
    CLK_MOUSE_IN = 1'b0;
    stop_fall_cyc = cyc;
    if (drop) begin
      idle(3);
      READ_ENABLE = 1'b0;
      idle(1);
      READ_ENABLE = 1'b1;
      idle(H - 4);
    end else begin
      idle(H);
    end
    CLK_MOUSE_IN = 1'b1;
    DATA_MOUSE_IN = 1'b1;
    idle(H);
  endtask

  task automatic test_reset;
    idle(5);
    n_checks++;
    if (BYTE_READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", BYTE_READY); end
    n_checks++;
    if (BYTE_READ !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h exp 00", BYTE_READ); end
    n_checks++;
    if (BYTE_ERROR_CODE !== 2'b00) begin n_fail++; $display("FAIL reset_code got %b exp 00", BYTE_ERROR_CODE); end
    RESET = 1'b1;
    idle(5);
  endtask

  task automatic test_valid_frame;
    int p0, lat;
    p0 = pulse_cnt;
    send_frame(8'hFA, 1'b1, 1'b1, 1'b0);
    lat = pulse_cyc - stop_fall_cyc;
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL valid_pulses got %0d exp 1", pulse_cnt - p0); end
    n_checks++;
    if (cap_byte !== 8'hFA) begin n_fail++; $display("FAIL valid_byte got %h exp fa", cap_byte); end
    n_checks++;
    if (cap_code !== 2'b00) begin n_fail++; $display("FAIL valid_code got %b exp 00", cap_code); end
    n_checks++;
    if (lat < 4 || lat > 5) begin n_fail++; $display("FAIL valid_latency got %0d exp 4..5", lat); end
  endtask

  task automatic test_parity_error;
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL par_pulses got %0d exp 1", pulse_cnt - p0); end
    n_checks++;
    if (cap_byte !== 8'h00) begin n_fail++; $display("FAIL par_byte got %h exp 00", cap_byte); end
    n_checks++;
    if (cap_code !== 2'b01) begin n_fail++; $display("FAIL par_code got %b exp 01", cap_code); end
  endtask

  task automatic test_stop_error;
    int p0;
    p0 = pulse_cnt;
    send_frame(8'hAA, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL stop_pulses got %0d exp 1", pulse_cnt - p0); end
    n_checks++;
    if (cap_byte !== 8'hAA) begin n_fail++; $display("FAIL stop_byte got %h exp aa", cap_byte); end
    n_checks++;
    if (cap_code !== 2'b10) begin n_fail++; $display("FAIL stop_code got %b exp 10", cap_code); end
  endtask

  task automatic test_back_to_back;
    int p0;
    p0 = pulse_cnt;
    send_frame(8'hFA, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (cap_byte !== 8'hFA) begin n_fail++; $display("FAIL b2b_first got %h exp fa", cap_byte); end
    send_frame(8'h08, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (pulse_cnt - p0 !== 2) begin n_fail++; $display("FAIL b2b_pulses got %0d exp 2", pulse_cnt - p0); end
    n_checks++;
    if (cap_byte !== 8'h08) begin n_fail++; $display("FAIL b2b_second got %h exp 08", cap_byte); end
    n_checks++;
    if (cap_code !== 2'b00) begin n_fail++; $display("FAIL b2b_code got %b exp 00", cap_code); end
  endtask

  task automatic test_abort;
    int p0;
    p0 = pulse_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    READ_ENABLE = 1'b0;
    // The rest of the frame arrives while reception is disabled.
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    idle(10);
    n_checks++;
    if (pulse_cnt - p0 !== 0) begin n_fail++; $display("FAIL abort_pulses got %0d exp 0", pulse_cnt - p0); end
    n_checks++;
    if (BYTE_READ !== 8'h08) begin n_fail++; $display("FAIL abort_held got %h exp 08", BYTE_READ); end
    READ_ENABLE = 1'b1;
    idle(10);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL abort_resume_pulses got %0d exp 1", pulse_cnt - p0); end
    n_checks++;
    if (cap_byte !== 8'h55) begin n_fail++; $display("FAIL abort_resume_byte got %h exp 55", cap_byte); end
  endtask

  task automatic test_done_priority;
    int p0;
    p0 = pulse_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL done_prio_pulses got %0d exp 1", pulse_cnt - p0); end
    n_checks++;
    if (cap_byte !== 8'h3C) begin n_fail++; $display("FAIL done_prio_byte got %h exp 3c", cap_byte); end
  endtask

  task automatic test_reset_mid_frame;
    int p0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    idle(2);
    n_checks++;
    if (BYTE_READ !== 8'h00) begin n_fail++; $display("FAIL midrst_byte got %h exp 00", BYTE_READ); end
    n_checks++;
    if (BYTE_ERROR_CODE !== 2'b00) begin n_fail++; $display("FAIL midrst_code got %b exp 00", BYTE_ERROR_CODE); end
    n_checks++;
    if (BYTE_READY !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b exp 0", BYTE_READY); end
    RESET = 1'b1;
    idle(5);
    p0 = pulse_cnt;
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL midrst_pulses got %0d exp 1", pulse_cnt - p0); end
    n_checks++;
    if (cap_byte !== 8'h12) begin n_fail++; $display("FAIL midrst_resume_byte got %h exp 12", cap_byte); end
  endtask

  task automatic test_timeout;
    int p0;
    logic [7:0] exp_byte;
    logic [1:0] exp_code;
`ifdef PS2_RX_TIMEOUT_EN
    exp_byte = 8'hF4;
    exp_code = 2'b00;
`else
    // The stalled frame absorbs the next frame's first edges: bits 1,0,1 then
    // start 0 and F4 bits 0,0,1,0 -> 0x45; parity edge 1 -> even count.
    exp_byte = 8'h45;
    exp_code = 2'b01;
`endif
    p0 = pulse_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    idle(50100);
    n_checks++;
    if (pulse_cnt - p0 !== 0) begin n_fail++; $display("FAIL tmo_idle_pulses got %0d exp 0", pulse_cnt - p0); end
    send_frame(8'hF4, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (pulse_cnt - p0 !== 1) begin n_fail++; $display("FAIL tmo_pulses got %0d exp 1", pulse_cnt - p0); end
    n_checks++;
    if (cap_byte !== exp_byte) begin n_fail++; $display("FAIL tmo_byte got %h exp %h", cap_byte, exp_byte); end
    n_checks++;
    if (cap_code !== exp_code) begin n_fail++; $display("FAIL tmo_code got %b exp %b", cap_code, exp_code); end
  endtask

  initial begin
    test_reset;
    test_valid_frame;
    test_parity_error;
    test_stop_error;
    test_back_to_back;
    test_abort;
    test_done_priority;
    test_reset_mid_frame;
    test_timeout;
    n_checks++;
    if (wide_cnt !== 0) begin n_fail++; $display("FAIL pulse_width extra_high_cycles %0d exp 0", wide_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_receiver.md
# ps2_mouse_receiver

Receives 11-bit PS/2 device-to-host frames (start, 8 data LSB-first, odd parity, stop) from the mouse CLK/DATA lines, runs in the 50 MHz CLK domain, and presents each byte with error status to the mouse master state machine. Sits beside the mouse transmitter on the same bidirectional lines. The master deasserts READ_ENABLE while the transmitter drives the bus.

## Interface
- TIMEOUT_CYCLES, default 50000: CLK cycles without a PS/2 falling edge before an in-progress frame is abandoned (1 ms at 50 MHz).
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  asynchronous, active-low reset.
- CLK_MOUSE_IN  in  1  raw PS/2 clock line. Asynchronous.
- DATA_MOUSE_IN  in  1  raw PS/2 data line. Asynchronous.
- READ_ENABLE  in  1  high = reception permitted. Low = abort to IDLE and ignore the lines.
- BYTE_READY  out  1  one-CLK pulse when a complete frame has been received.
- BYTE_READ  out  8  last received data byte. Held until the next BYTE_READY.
- BYTE_ERROR_CODE  out  2  bit0 = parity error, bit1 = stop-bit error. Valid with BYTE_READY, held after.

## Operation
- Synchronisers:
  - CLK_MOUSE_IN and DATA_MOUSE_IN each feed a 3-flop shift register (clk_dly, data_dly).
  - Falling edge (clk_fall) = clk_dly[2]==1 && clk_dly[1]==0.
  - The sampled data bit is data_dly[1], which is aligned with the edge.
- States (one-hot): IDLE, DATA, PARITY, STOP, DONE.
  - IDLE: on clk_fall with data 0 → DATA, bit_cnt=0. On clk_fall with data 1 → stay in IDLE (bad start, discarded).
  - DATA: on each clk_fall, shreg <= {data, shreg[7:1]} and bit_cnt++. When clk_fall occurs with bit_cnt==7 → PARITY.
  - PARITY: on clk_fall, parity_err <= ~(^shreg ^ data) (the 9 bits must hold an odd number of ones) → STOP.
  - STOP: on clk_fall, stop_err <= ~data → DONE.
  - DONE: for one cycle, BYTE_READY=1, BYTE_READ<=shreg, BYTE_ERROR_CODE<={stop_err,parity_err} → IDLE.
- Error frames still pulse BYTE_READY. The master decides whether to discard them.
- READ_ENABLE low in any state: next state is IDLE, bit_cnt cleared, no BYTE_READY. BYTE_READ and BYTE_ERROR_CODE are unchanged.
- READ_ENABLE low in the same cycle as DONE: DONE takes priority and the pulse is issued.
- bit_cnt is 3 bits. It wraps only under the exit condition, so there is no overflow path.

## Timing
- Reset values: BYTE_READY=0, BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, state=IDLE, synchronisers=3'b111 (idle-high lines).
- Pin-to-clk_fall latency: 2-3 CLK.
- Stop-bit falling edge on the pin → BYTE_READY high 4-5 CLK later. The DONE cycle is exactly one cycle long.
- BYTE_READ and BYTE_ERROR_CODE change only in the DONE cycle, coincident with BYTE_READY.
- Back-to-back frames: DONE→IDLE completes well within one PS/2 bit period (≥60 µs), so no frame is lost.
- Reset asserted mid-frame: all state clears immediately. After release, reception resumes at the next start bit.

## Configuration
- PS2_RX_TIMEOUT_EN defined:
  - A 17-bit watchdog counter clears on every clk_fall and in IDLE, and counts otherwise.
  - When the counter reaches TIMEOUT_CYCLES-1 outside IDLE, state → IDLE with no BYTE_READY, and outputs are unchanged.
- PS2_RX_TIMEOUT_EN undefined: no counter. A partial frame waits indefinitely for further edges; only READ_ENABLE low or RESET recovers it.

## Test plan
- Valid frame 0xFA, parity 1, stop 1, READ_ENABLE=1 → single BYTE_READY pulse, BYTE_READ=8'hFA, BYTE_ERROR_CODE=2'b00.
- Frame 0x00, parity 0 (wrong), stop 1 → BYTE_READY, BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b01.
- Frame 0xAA, parity 1, stop 0 → BYTE_READ=8'hAA, BYTE_ERROR_CODE=2'b10.
- Two back-to-back frames 0xFA then 0x08 (parity 0) → two pulses; BYTE_READ is 8'hFA then 8'h08, both with code 00.
- READ_ENABLE dropped after the 4th data edge, raised again, then a full frame 0x55 → no pulse for the aborted frame, then BYTE_READ=8'h55.
- With PS2_RX_TIMEOUT_EN: stop clocking after 3 data bits for 50000 CLK, then send 0xF4 → no pulse at timeout, then BYTE_READ=8'hF4, code 00. Without the macro, the same stimulus gives a corrupted byte, which documents the difference.
